// File: rtl/ex_div_iter.sv
// Iterative restoring divider, one quotient bit per cycle, signed/unsigned, with annul.
// Optional divide-by-zero fast path and dbz_o flag under `EX_DIV_ZERO_DETECT_EN.
module ex_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic             annul_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] quot_o,
`ifdef EX_DIV_ZERO_DETECT_EN
  output logic             dbz_o,
`endif
  output logic [WIDTH-1:0] rem_o
);
  localparam int CW = $clog2(WIDTH) + 1;

`ifdef EX_DIV_ZERO_DETECT_EN
  typedef enum logic [1:0] {IDLE, RUN, DONE, ZERO} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_r, quo_r, dvs_r;
  logic             neg_q, neg_r;

  // A zero divisor keeps the dividend raw so the plain iteration yields
  // quotient all-ones and remainder == dividend exactly as presented.
  logic dvs_zero, a_neg, b_neg;
  assign dvs_zero = (divisor_i == '0);
  assign a_neg    = signed_i & dividend_i[WIDTH-1] & ~dvs_zero;
  assign b_neg    = signed_i & divisor_i[WIDTH-1];

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             qbit;
  assign shifted = {rem_r, quo_r[WIDTH-1]};
  assign diff    = {1'b0, shifted} - {2'b00, dvs_r};
  assign qbit    = ~diff[WIDTH+1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      busy_o  <= 1'b0;
      ready_o <= 1'b0;
      quot_o  <= '0;
      rem_o   <= '0;
      rem_r   <= '0;
      quo_r   <= '0;
      dvs_r   <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
`ifdef EX_DIV_ZERO_DETECT_EN
      dbz_o   <= 1'b0;
`endif
    end else begin
      ready_o <= 1'b0;
      case (state)
        IDLE: if (start_i && !annul_i) begin
          quo_r  <= a_neg ? -dividend_i : dividend_i;
          dvs_r  <= b_neg ? -divisor_i : divisor_i;
          rem_r  <= '0;
          neg_q  <= a_neg ^ b_neg;
          neg_r  <= a_neg;
          cnt    <= '0;
          busy_o <= 1'b1;
`ifdef EX_DIV_ZERO_DETECT_EN
          state  <= dvs_zero ? ZERO : RUN;
`else
          state  <= RUN;
`endif
        end
        RUN: if (annul_i) begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end else begin
          rem_r <= qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
          quo_r <= {quo_r[WIDTH-2:0], qbit};
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) state <= DONE;
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          if (!annul_i) begin
            quot_o  <= neg_q ? -quo_r : quo_r;
            rem_o   <= neg_r ? -rem_r : rem_r;
            ready_o <= 1'b1;
`ifdef EX_DIV_ZERO_DETECT_EN
            dbz_o   <= 1'b0;
`endif
          end
        end
`ifdef EX_DIV_ZERO_DETECT_EN
        ZERO: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          if (!annul_i) begin
            quot_o  <= '1;
            rem_o   <= quo_r;
            ready_o <= 1'b1;
            dbz_o   <= 1'b1;
          end
        end
`endif
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ex_div_iter.sv
// Directed bench for ex_div_iter (WIDTH=32): vector table plus annul/reset/start-flood sequences.
module tb_ex_div_iter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start_i, signed_i, annul_i;
  logic [W-1:0] dividend_i, divisor_i;
  logic         busy_o, ready_o;
  logic [W-1:0] quot_o, rem_o;
`ifdef EX_DIV_ZERO_DETECT_EN
  logic         dbz_o;
`endif

  ex_div_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i), .annul_i(annul_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .busy_o(busy_o), .ready_o(ready_o),
    .quot_o(quot_o),
`ifdef EX_DIV_ZERO_DETECT_EN
    .dbz_o(dbz_o),
`endif
    .rem_o(rem_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Caller is positioned 1ns after a rising edge; returns the same way.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output logic [W-1:0] q, output logic [W-1:0] r, output int lat);
    start_i = 1'b1; dividend_i = a; divisor_i = b; signed_i = s;
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("busy_after_accept", 64'(busy_o), 64'd1);
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (ready_o) begin lat = k; break; end
    end
    q = quot_o; r = rem_o;
  endtask

  typedef struct {
    logic [W-1:0] a, b;
    logic         s;
    logic [W-1:0] q, r;
  } vec_t;
  vec_t vt[12];

  initial begin
    logic [W-1:0] q, r;
    int lat, exp_lat, nrdy;

    vt[0]  = '{32'd100,      32'd7,          1'b0, 32'd14,         32'd2};
    vt[1]  = '{32'hFFFFFFF9, 32'd2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF};
    vt[2]  = '{32'h80000000, 32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0};
    vt[3]  = '{32'h80000000, 32'hFFFFFFFF,   1'b0, 32'd0,          32'h80000000};
    vt[4]  = '{32'd7,        32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'd1};
    vt[5]  = '{32'hFFFFFFF9, 32'hFFFFFFFE,   1'b1, 32'd3,          32'hFFFFFFFF};
    vt[6]  = '{32'hFFFFFFFF, 32'd1,          1'b0, 32'hFFFFFFFF,   32'd0};
    vt[7]  = '{32'hFFFFFFFF, 32'd10,         1'b0, 32'h19999999,   32'd5};
    vt[8]  = '{32'd5,        32'd9,          1'b0, 32'd0,          32'd5};
    vt[9]  = '{32'h00001234, 32'd0,          1'b1, 32'hFFFFFFFF,   32'h00001234};
    vt[10] = '{32'h80000000, 32'd0,          1'b1, 32'hFFFFFFFF,   32'h80000000};
    vt[11] = '{32'h12345678, 32'h00001000,   1'b0, 32'h00012345,   32'h00000678};

    rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
    dividend_i = '0; divisor_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd0);
    chk("rst_quot", 64'(quot_o), 64'd0);
    chk("rst_rem", 64'(rem_o), 64'd0);
`ifdef EX_DIV_ZERO_DETECT_EN
    chk("rst_dbz", 64'(dbz_o), 64'd0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_div(vt[i].a, vt[i].b, vt[i].s, q, r, lat);
`ifdef EX_DIV_ZERO_DETECT_EN
      exp_lat = (vt[i].b == '0) ? 1 : W + 1;
      chk($sformatf("v%0d_dbz", i), 64'(dbz_o), 64'(vt[i].b == '0));
`else
      exp_lat = W + 1;
`endif
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(exp_lat));
      chk($sformatf("v%0d_quot", i), 64'(q), 64'(vt[i].q));
      chk($sformatf("v%0d_rem", i), 64'(r), 64'(vt[i].r));
      chk($sformatf("v%0d_busy_at_ready", i), 64'(busy_o), 64'd0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_ready_pulse", i), 64'(ready_o), 64'd0);
      chk($sformatf("v%0d_quot_hold", i), 64'(quot_o), 64'(vt[i].q));
    end

    // Annul on RUN cycle 10, then restart immediately.
    run_div(32'd100, 32'd7, 1'b0, q, r, lat);
    start_i = 1'b1; dividend_i = 32'h1234; divisor_i = 32'd3; signed_i = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    annul_i = 1'b1;
    @(posedge clk); #1;
    annul_i = 1'b0;
    chk("annul_run_busy", 64'(busy_o), 64'd0);
    chk("annul_run_ready", 64'(ready_o), 64'd0);
    chk("annul_run_quot_hold", 64'(quot_o), 64'd14);
    chk("annul_run_rem_hold", 64'(rem_o), 64'd2);
    run_div(32'd1000, 32'd10, 1'b0, q, r, lat);
    chk("after_annul_lat", 64'(lat), 64'(W + 1));
    chk("after_annul_quot", 64'(q), 64'd100);
    chk("after_annul_rem", 64'(r), 64'd0);
    @(posedge clk); #1;

    // Annul in DONE: no pulse ever, outputs held.
    start_i = 1'b1; dividend_i = 32'd77; divisor_i = 32'd5; signed_i = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (W) @(posedge clk);
    #1;
    annul_i = 1'b1;
    @(posedge clk); #1;
    annul_i = 1'b0;
    chk("annul_done_busy", 64'(busy_o), 64'd0);
    nrdy = 0;
    for (int k = 0; k < 40; k++) begin
      if (ready_o) nrdy++;
      @(posedge clk); #1;
    end
    chk("annul_done_no_ready", 64'(nrdy), 64'd0);
    chk("annul_done_quot_hold", 64'(quot_o), 64'd100);

    // start_i held high: one result per 34 cycles, nothing queued.
    start_i = 1'b1; dividend_i = 32'd100; divisor_i = 32'd7; signed_i = 1'b0;
    nrdy = 0;
    for (int k = 1; k <= 3 * (W + 2); k++) begin
      @(posedge clk); #1;
      if (ready_o) begin
        nrdy++;
        chk($sformatf("flood_edge%0d", k), 64'(k % (W + 2)), 64'd0);
        chk("flood_quot", 64'(quot_o), 64'd14);
      end
    end
    start_i = 1'b0;
    chk("flood_count", 64'(nrdy), 64'd3);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (ready_o) nrdy++;
    end
    chk("flood_no_queue", 64'(nrdy), 64'd3);

    // Reset mid-RUN clears everything; first edge after reset accepts.
    start_i = 1'b1; dividend_i = 32'd50; divisor_i = 32'd3;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_run_busy", 64'(busy_o), 64'd0);
    chk("rst_run_ready", 64'(ready_o), 64'd0);
    chk("rst_run_quot", 64'(quot_o), 64'd0);
    chk("rst_run_rem", 64'(rem_o), 64'd0);
    run_div(32'd50, 32'd3, 1'b0, q, r, lat);
    chk("post_rst_lat", 64'(lat), 64'(W + 1));
    chk("post_rst_quot", 64'(q), 64'd16);
    chk("post_rst_rem", 64'(r), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
